// File: rtl/irq_controller.sv
//------------------------------------------------------------------------------
// Module   : irq_controller
// Function : Latches rising-edge interrupt requests as pending bits, masks them
//            and presents one source at a time over the ExtIRQ/ExtIAck handshake.
//            Optional macro IRQ_ROUND_ROBIN_EN selects round-robin arbitration
//            (default: fixed priority, lowest index wins).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_controller #(
  parameter int NSRC = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            ExtIAck,
  output logic            ExtIRQ,
  output logic [ID_W-1:0] irq_id,
  output logic [NSRC-1:0] pending,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [NSRC-1:0] r_srcQ;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_eligible;
  logic            r_extIrq;
  logic            w_extIrqNext;
  logic [ID_W-1:0] r_irqId;
  logic [ID_W-1:0] w_irqIdNext;
  logic [ID_W-1:0] w_winner;
  logic            w_anyEligible;

  assign w_rise     = irq_src & ~r_srcQ;
  assign w_eligible = r_pending & irq_mask;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_rrPtr;
  logic [ID_W-1:0] w_rrPtrNext;

  // Walk the ring downwards so the entry closest to r_rrPtr is assigned last.
  always_comb begin
    w_winner      = '0;
    w_anyEligible = 1'b0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (w_eligible[(int'(r_rrPtr) + k) % NSRC]) begin
        w_winner      = ID_W'((int'(r_rrPtr) + k) % NSRC);
        w_anyEligible = 1'b1;
      end
    end
  end

  always_comb begin
    w_rrPtrNext = r_rrPtr;
    if (r_state == ST_REQ && ExtIAck) begin
      w_rrPtrNext = (r_irqId == ID_W'(NSRC - 1)) ? '0 : r_irqId + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_rrPtr <= '0;
    else       r_rrPtr <= w_rrPtrNext;
  end
`else
  always_comb begin
    w_winner      = '0;
    w_anyEligible = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner      = ID_W'(i);
        w_anyEligible = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_stateNext  = r_state;
    w_extIrqNext = r_extIrq;
    w_irqIdNext  = r_irqId;
    w_clr        = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_anyEligible) begin
          w_irqIdNext  = w_winner;
          w_extIrqNext = 1'b1;
          w_stateNext  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ExtIAck) begin
          for (int i = 0; i < NSRC; i++) begin
            if (ID_W'(i) == r_irqId) w_clr[i] = 1'b1;
          end
          w_extIrqNext = 1'b0;
          w_stateNext  = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        // A held-high ack must drop before another source can be offered.
        if (!ExtIAck) w_stateNext = ST_IDLE;
      end
      default: begin
        w_extIrqNext = 1'b0;
        w_stateNext  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_srcQ    <= '0;
      r_pending <= '0;
      r_extIrq  <= 1'b0;
      r_irqId   <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_srcQ    <= irq_src;
      // A new edge on the same cycle as its clear keeps the source pending.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_extIrq  <= w_extIrqNext;
      r_irqId   <= w_irqIdNext;
    end
  end

  assign ExtIRQ  = r_extIrq;
  assign irq_id  = r_irqId;
  assign pending = r_pending;
  assign busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_irq_controller
// Function : Self-checking bench for irq_controller against a cycle-level
//            behavioural model; honours IRQ_ROUND_ROBIN_EN like the design.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_irq_controller;

  localparam int NSRC = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NSRC-1:0] irqSrc = '0;
  logic [NSRC-1:0] irqMask = '0;
  logic            extIAck = 1'b0;
  logic            extIrq;
  logic [ID_W-1:0] irqId;
  logic [NSRC-1:0] pendingOut;
  logic            busyOut;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [NSRC-1:0] mPrev = '0;
  logic [NSRC-1:0] mPend = '0;
  int              mPresent = -1;  // source currently offered, -1 when none
  bit              mHold = 1'b0;   // ack seen, waiting for it to drop
  int              mPtr = 0;
  int              mId = 0;

  irq_controller #(.NSRC(NSRC), .ID_W(ID_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_src  (irqSrc),
    .irq_mask (irqMask),
    .ExtIAck  (extIAck),
    .ExtIRQ   (extIrq),
    .irq_id   (irqId),
    .pending  (pendingOut),
    .busy     (busyOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pickWinner(input logic [NSRC-1:0] elig, input int start);
    int cand;
    for (int k = 0; k < NSRC; k++) begin
`ifdef IRQ_ROUND_ROBIN_EN
      cand = (start + k) % NSRC;
`else
      cand = k;
`endif
      if (elig[cand]) return cand;
    end
    return -1;
  endfunction

  task automatic modelStep(input bit r, input logic [NSRC-1:0] s,
                           input logic [NSRC-1:0] m, input bit a);
    logic [NSRC-1:0] rise;
    int clearIdx;
    int w;
    if (r) begin
      mPrev = '0; mPend = '0; mPresent = -1; mHold = 0; mPtr = 0; mId = 0;
      return;
    end
    rise = s & ~mPrev;
    clearIdx = -1;
    if (mPresent >= 0) begin
      if (a) begin
        clearIdx = mPresent;
        mPtr = (mPresent + 1) % NSRC;
        mPresent = -1;
        mHold = 1;
      end
    end else if (mHold) begin
      if (!a) mHold = 0;
    end else begin
      w = pickWinner(mPend & m, mPtr);
      if (w >= 0) begin
        mPresent = w;
        mId = w;
      end
    end
    if (clearIdx >= 0) mPend[clearIdx] = 1'b0;
    mPend = mPend | rise;
    mPrev = s;
  endtask

  task automatic cycle(input bit r, input logic [NSRC-1:0] s,
                       input logic [NSRC-1:0] m, input bit a);
    @(negedge clk);
    reset = r; irqSrc = s; irqMask = m; extIAck = a;
    @(posedge clk);
    modelStep(r, s, m, a);
    #1;
    check("ExtIRQ",  32'(extIrq),     32'(mPresent >= 0));
    check("pending", 32'(pendingOut), 32'(mPend));
    check("busy",    32'(busyOut),    32'((mPresent >= 0) || mHold));
    if (r || mPresent >= 0) check("irq_id", 32'(irqId), 32'(mId));
  endtask

  // Acknowledge whenever the model says a request is up.
  task automatic serve(input int n, input logic [NSRC-1:0] s, input logic [NSRC-1:0] m);
    for (int i = 0; i < n; i++) cycle(1'b0, s, m, mPresent >= 0);
  endtask

  initial begin
    logic [NSRC-1:0] s;
    logic [NSRC-1:0] m;
    bit              r;
    bit              a;

    // T1: single source, full handshake
    cycle(1, 4'b0000, 4'b1111, 0);
    cycle(1, 4'b0000, 4'b1111, 0);
    cycle(0, 4'b0001, 4'b1111, 0);
    cycle(0, 4'b0001, 4'b1111, 0);
    check("T1_req", 32'(extIrq), 32'd1);
    check("T1_id",  32'(irqId),  32'd0);
    cycle(0, 4'b0001, 4'b1111, 1);
    check("T1_pend", 32'(pendingOut), 32'd0);
    cycle(0, 4'b0000, 4'b1111, 0);
    check("T1_busy", 32'(busyOut), 32'd0);

    // T2: two simultaneous edges
    cycle(0, 4'b0110, 4'b1111, 0);
    serve(12, 4'b0000, 4'b1111);

    // T3: masked source becomes visible when unmasked
    cycle(0, 4'b0100, 4'b1011, 0);
    cycle(0, 4'b0100, 4'b1011, 0);
    cycle(0, 4'b0000, 4'b1011, 0);
    check("T3_masked", 32'(extIrq), 32'd0);
    cycle(0, 4'b0000, 4'b1111, 0);
    cycle(0, 4'b0000, 4'b1111, 0);
    check("T3_id", 32'(irqId), 32'd2);
    serve(4, 4'b0000, 4'b1111);

    // T4: re-edge on the ack cycle keeps the source pending
    cycle(0, 4'b1000, 4'b1111, 0);
    cycle(0, 4'b1000, 4'b1111, 0);
    cycle(0, 4'b0000, 4'b1111, 0);
    cycle(0, 4'b1000, 4'b1111, 1);
    check("T4_pend3", 32'(pendingOut[3]), 32'd1);
    serve(8, 4'b1000, 4'b1111);

    // T5: held ack retires only one source
    cycle(0, 4'b0011, 4'b1111, 0);
    cycle(0, 4'b0011, 4'b1111, 0);
    for (int i = 0; i < 5; i++) cycle(0, 4'b0011, 4'b1111, 1);
    serve(8, 4'b0011, 4'b1111);

    // T6: reset in the middle of a request
    cycle(0, 4'b0000, 4'b1111, 0);
    cycle(0, 4'b1000, 4'b1111, 0);
    cycle(0, 4'b1000, 4'b1111, 0);
    cycle(1, 4'b1000, 4'b1111, 0);
    cycle(0, 4'b1000, 4'b1111, 0);
    cycle(0, 4'b1000, 4'b1111, 0);
    check("T6_req", 32'(extIrq), 32'd1);
    serve(6, 4'b0000, 4'b1111);

    // Random traffic
    s = '0;
    m = 4'b1111;
    for (int n = 0; n < 2000; n++) begin
      r = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(0, 5) == 0) s[i] = ~s[i];
      if ($urandom_range(0, 15) == 0) m = NSRC'($urandom);
      if (mPresent >= 0) a = ($urandom_range(0, 2) != 0);
      else               a = ($urandom_range(0, 3) == 0);
      cycle(r, s, m, a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
